// File: rtl/piano_pkg.sv
// Shared types and constants for the piano UART transmit path.
package piano_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] TYPE_NOTE = 8'h01;
    localparam logic [7:0] TYPE_CMD  = 8'h02;
    localparam logic [7:0] NOTE_NONE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } tx_state_t;

    typedef enum logic {
        GRANT_NOTE = 1'b0,
        GRANT_CMD  = 1'b1
    } grant_t;

    // Byte at position idx of a packet: SYNC, TYPE, PAYLOAD, CHK (TYPE ^ PAYLOAD).
    function automatic logic [7:0] pkt_byte(input logic [1:0] idx,
                                            input logic [7:0] sync,
                                            input logic [7:0] typ,
                                            input logic [7:0] payload);
        case (idx)
            2'd0:    pkt_byte = sync;
            2'd1:    pkt_byte = typ;
            2'd2:    pkt_byte = payload;
            default: pkt_byte = typ ^ payload;
        endcase
    endfunction

endpackage

// File: rtl/piano_pkt_serializer.sv
// Sequences one snapshotted 4-byte packet into the UART using the
// tx_start / tx_busy handshake, with a timeout if tx_busy never rises.
module piano_pkt_serializer #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter logic [7:0]  SYNC_BYTE   = piano_pkg::SYNC_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       launch,
    input  logic [7:0] pkt_type,
    input  logic [7:0] pkt_payload,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       pkt_active,
    output logic       ser_idle
);
    import piano_pkg::*;

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    tx_state_t        state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       type_q, type_d;
    logic [7:0]       payload_q, payload_d;
    logic [7:0]       data_q, data_d;
    logic             active_q, active_d;
    logic             byte_done;

    assign tx_data    = data_q;
    assign pkt_active = active_q;
    assign ser_idle   = (state_q == IDLE);

    // Next-state, byte sequencing and the start pulse.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        type_d    = type_q;
        payload_d = payload_q;
        data_d    = data_q;
        active_d  = active_q;
        tx_start  = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    type_d    = pkt_type;
                    payload_d = pkt_payload;
                    idx_d     = 2'd0;
                    active_d  = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                data_d  = pkt_byte(2'd0, SYNC_BYTE, type_q, payload_q);
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    tmo_d    = '0;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // UART never acknowledged; treat the byte as sent.
                    byte_done = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (byte_done) begin
            if (idx_q == 2'd3) begin
                state_d  = IDLE;
                active_d = 1'b0;
            end else begin
                idx_d   = idx_q + 2'd1;
                data_d  = pkt_byte(idx_q + 2'd1, SYNC_BYTE, type_q, payload_q);
                state_d = SEND;
            end
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            type_q    <= '0;
            payload_q <= '0;
            data_q    <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            type_q    <= type_d;
            payload_q <= payload_d;
            data_q    <= data_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: rtl/piano_tx_scheduler.sv
// Owns the UART: note dedup and periodic re-send, a one-deep command slot,
// round-robin arbitration, and the packet serializer.
module piano_tx_scheduler #(
    parameter int unsigned REPEAT_CYCLES = 20_000_000,
    parameter int unsigned ACK_TIMEOUT   = 16,
    parameter logic [7:0]  SYNC_BYTE     = piano_pkg::SYNC_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [7:0] note_code,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_code,
    output logic       cmd_ready,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       pkt_active,
    output logic [7:0] note_drops
);
    import piano_pkg::*;

    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    // Pending is raised one count early so the re-send lands exactly
    // REPEAT_CYCLES after the previous launch; the timer then holds at R-1.
    localparam logic [RPT_W-1:0] RPT_SET  = RPT_W'(REPEAT_CYCLES - 2);
    localparam logic [RPT_W-1:0] RPT_HOLD = RPT_W'(REPEAT_CYCLES - 1);

    logic [7:0]       last_sent_q, last_sent_d;
    logic             pending_q, pending_d;
    logic [7:0]       pend_note_q, pend_note_d;
    logic [RPT_W-1:0] repeat_q, repeat_d;
    logic [7:0]       drops_q, drops_d;
    logic             cmd_full_q, cmd_full_d;
    logic [7:0]       cmd_code_q, cmd_code_d;
    grant_t           last_grant_q, last_grant_d;

    logic             ser_idle;
    logic             launch;
    logic             grant_note;
    logic             launch_note;
    logic [7:0]       pkt_type;
    logic [7:0]       pkt_payload;

    assign cmd_ready   = !cmd_full_q;
    assign note_drops  = drops_q;
    assign pkt_type    = grant_note ? TYPE_NOTE : TYPE_CMD;
    assign pkt_payload = grant_note ? pend_note_q : cmd_code_q;

    // Arbitration, note dedup, repeat timer and command slot.
    always_comb begin
        last_sent_d  = last_sent_q;
        pending_d    = pending_q;
        pend_note_d  = pend_note_q;
        repeat_d     = repeat_q;
        drops_d      = drops_q;
        cmd_full_d   = cmd_full_q;
        cmd_code_d   = cmd_code_q;
        last_grant_d = last_grant_q;
        launch       = 1'b0;
        grant_note   = 1'b0;

        if (ser_idle && (pending_q || cmd_full_q)) begin
            launch = 1'b1;
            if (pending_q && cmd_full_q) begin
                grant_note = (last_grant_q == GRANT_CMD);
            end else begin
                grant_note = pending_q;
            end
            last_grant_d = grant_note ? GRANT_NOTE : GRANT_CMD;
        end
        launch_note = launch && grant_note;

        if (launch_note) begin
            last_sent_d = pend_note_q;
            pending_d   = 1'b0;
            repeat_d    = '0;
        end else if (last_sent_q != NOTE_NONE && !pending_q) begin
            if (repeat_q >= RPT_SET) begin
                pending_d   = 1'b1;
                pend_note_d = last_sent_q;
                repeat_d    = RPT_HOLD;
            end else begin
                repeat_d = repeat_q + RPT_W'(1);
            end
        end

        // Compare against the post-launch last_sent so a note held across
        // its own launch does not re-arm itself.
        if (note_valid) begin
            if (note_code != last_sent_d) begin
                if (pending_q && !launch_note && pend_note_q != note_code &&
                    drops_q != 8'hFF) begin
                    drops_d = drops_q + 8'd1;
                end
                pending_d   = 1'b1;
                pend_note_d = note_code;
            end else begin
                pending_d = 1'b0;
            end
        end

        if (launch && !grant_note) begin
            cmd_full_d = 1'b0;
        end
        if (cmd_valid && !cmd_full_q) begin
            cmd_full_d = 1'b1;
            cmd_code_d = cmd_code;
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_sent_q  <= NOTE_NONE;
            pending_q    <= 1'b0;
            pend_note_q  <= NOTE_NONE;
            repeat_q     <= '0;
            drops_q      <= '0;
            cmd_full_q   <= 1'b0;
            cmd_code_q   <= '0;
            last_grant_q <= GRANT_CMD;
        end else begin
            last_sent_q  <= last_sent_d;
            pending_q    <= pending_d;
            pend_note_q  <= pend_note_d;
            repeat_q     <= repeat_d;
            drops_q      <= drops_d;
            cmd_full_q   <= cmd_full_d;
            cmd_code_q   <= cmd_code_d;
            last_grant_q <= last_grant_d;
        end
    end

    piano_pkt_serializer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .SYNC_BYTE   (SYNC_BYTE)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .launch      (launch),
        .pkt_type    (pkt_type),
        .pkt_payload (pkt_payload),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .pkt_active  (pkt_active),
        .ser_idle    (ser_idle)
    );

endmodule

// File: tb/tb_piano_tx_scheduler.sv
// Directed bench for piano_tx_scheduler with a simple UART responder.
module tb_piano_tx_scheduler;

    localparam int unsigned RPT = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       note_valid = 1'b0;
    logic [7:0] note_code = 8'h00;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_code = 8'h00;
    logic       tx_busy = 1'b0;
    logic       cmd_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       pkt_active;
    logic [7:0] note_drops;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic uart_mute = 1'b0;

    int         st_cyc[$];
    logic [7:0] st_dat[$];
    logic       st_rdy[$];

    always #5 clk = ~clk;

    piano_tx_scheduler #(
        .REPEAT_CYCLES (RPT),
        .ACK_TIMEOUT   (16),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note_valid (note_valid),
        .note_code  (note_code),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .pkt_active (pkt_active),
        .note_drops (note_drops)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy for 10 cycles starting the cycle after tx_start
    always @(posedge clk) begin
        if (tx_start && !uart_mute) begin
            tx_busy  <= 1'b1;
            busy_cnt <= 10;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end
    end

    // Record every start pulse
    always @(negedge clk) begin
        if (tx_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(tx_data);
            st_rdy.push_back(cmd_ready);
            check("start_while_busy", 32'(tx_busy), 32'd0);
        end
    end

    function automatic int st_c(input int i);
        return (i < st_cyc.size()) ? st_cyc[i] : -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        note_valid = 1'b0;
        cmd_valid = 1'b0;
        ticks(16);
        reset = 1'b0;
        tick();
        st_cyc.delete();
        st_dat.delete();
        st_rdy.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_pkt_active"}, 32'(pkt_active), 32'd0);
        check({tag, "_note_drops"}, 32'(note_drops), 32'd0);
    endtask

    task automatic pulse_note(input logic [7:0] code);
        note_code = code;
        note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && st_cyc.size() < n; i++) tick();
        check({tag, "_start_count"}, 32'(st_cyc.size() >= n), 32'd1);
    endtask

    task automatic expect_pkt(input string tag, input int base, input logic [7:0] typ,
                              input logic [7:0] pay, input logic [7:0] chk);
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hA5;
        exp_b[1] = typ;
        exp_b[2] = pay;
        exp_b[3] = chk;
        for (int k = 0; k < 4; k++) begin
            if (base + k < st_dat.size())
                check($sformatf("%s_b%0d", tag, k), 32'(st_dat[base + k]), 32'(exp_b[k]));
            else
                check($sformatf("%s_b%0d_missing", tag, k), 32'd0, 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;

        // Held note 3: one packet, then a re-send exactly RPT cycles later
        do_reset();
        check_reset("rst");
        note_code = 8'h03;
        note_valid = 1'b1;
        c0 = cyc;
        ticks(100);
        note_valid = 1'b0;
        wait_starts("s1_first", 4, 100);
        check("s1_latency", 32'(st_c(0)), 32'(c0 + 3));
        expect_pkt("s1_pkt", 0, 8'h01, 8'h03, 8'h02);
        wait_until(st_c(0) + int'(RPT) - 1);
        check("s1_quiet", 32'(st_cyc.size()), 32'd4);
        wait_starts("s1_rep", 8, 200);
        check("s1_rep_gap", 32'(st_c(4) - st_c(0)), 32'(RPT));
        expect_pkt("s1_rep", 4, 8'h01, 8'h03, 8'h02);

        // Notes 2 then 5 overwrite each other mid-packet
        do_reset();
        pulse_note(8'h01);
        wait_starts("s2_a", 1, 20);
        pulse_note(8'h02);
        note_code = 8'h05;
        note_valid = 1'b1;
        ticks(150);
        note_valid = 1'b0;
        wait_starts("s2_b", 8, 200);
        expect_pkt("s2_p1", 0, 8'h01, 8'h01, 8'h00);
        expect_pkt("s2_p2", 4, 8'h01, 8'h05, 8'h04);
        check("s2_drops", 32'(note_drops), 32'd1);

        // Note and command pending together: note wins, then command
        do_reset();
        note_code = 8'h03;
        note_valid = 1'b1;
        cmd_code = 8'h10;
        cmd_valid = 1'b1;
        tick();
        note_valid = 1'b0;
        cmd_valid = 1'b0;
        check("s3_rdy_after_accept", 32'(cmd_ready), 32'd0);
        wait_starts("s3", 8, 300);
        expect_pkt("s3_note", 0, 8'h01, 8'h03, 8'h02);
        expect_pkt("s3_cmd", 4, 8'h02, 8'h10, 8'h12);
        check("s3_rdy_note_last", 32'((st_rdy.size() > 3) ? st_rdy[3] : 1'b1), 32'd0);
        check("s3_rdy_cmd_first", 32'((st_rdy.size() > 4) ? st_rdy[4] : 1'b0), 32'd1);

        // UART never raises busy: timeout advances each byte
        do_reset();
        uart_mute = 1'b1;
        pulse_note(8'h06);
        wait_starts("s4", 4, 200);
        for (int i = 1; i < 4; i++)
            check($sformatf("s4_gap%0d", i), 32'(st_c(i) - st_c(i - 1)), 32'd17);
        expect_pkt("s4_pkt", 0, 8'h01, 8'h06, 8'h07);
        wait_until(st_c(3) + 16);
        check("s4_active_before_end", 32'(pkt_active), 32'd1);
        tick();
        check("s4_active_after_end", 32'(pkt_active), 32'd0);
        ticks(40);
        check("s4_no_extra", 32'(st_cyc.size()), 32'd4);
        uart_mute = 1'b0;

        // Change-and-revert cancels; FF is sent once and never repeated
        do_reset();
        pulse_note(8'h03);
        wait_starts("s5_a", 1, 20);
        pulse_note(8'h04);
        pulse_note(8'h03);
        for (int i = 0; i < 200 && pkt_active; i++) tick();
        check("s5_pkt_done", 32'(pkt_active), 32'd0);
        ticks(60);
        check("s5_cancelled", 32'(st_cyc.size()), 32'd4);
        check("s5_drops", 32'(note_drops), 32'd0);
        pulse_note(8'hFF);
        wait_starts("s5_b", 8, 100);
        expect_pkt("s5_p1", 0, 8'h01, 8'h03, 8'h02);
        expect_pkt("s5_ff", 4, 8'h01, 8'hFF, 8'hFE);
        ticks(int'(RPT) + 100);
        check("s5_no_repeat", 32'(st_cyc.size()), 32'd8);

        // Reset during the payload byte, then a clean packet
        do_reset();
        pulse_note(8'h07);
        wait_starts("s6_a", 3, 100);
        reset = 1'b1;
        tick();
        check_reset("s6_rst");
        do_reset();
        pulse_note(8'h07);
        wait_starts("s6_b", 4, 200);
        expect_pkt("s6_pkt", 0, 8'h01, 8'h07, 8'h06);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piano_tx_scheduler.md
Name: piano_tx_scheduler

Overview:
- Owns the single UART transmitter. Arbitrates between the note stream from the piano key-mapping logic and a one-deep command requester (filter mode, status).
- Frames each message as a 4-byte packet and sequences the bytes into the UART with a start/busy handshake.
- Suppresses duplicate notes and re-sends a held note periodically. This replaces the fixed one-second sampler on the note path.

Parameters:
- REPEAT_CYCLES, 20_000_000: cycles between re-sends of an unchanged held note (1 s at 20 MHz).
- ACK_TIMEOUT, 16: cycles to wait for tx_busy to rise after tx_start before treating the byte as sent.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- note_valid  in  1  note_code qualifier; may be high every cycle
- note_code  in  8  key index 0..7, or 8'hFF for no key
- cmd_valid  in  1  command request
- cmd_code  in  8  command payload
- cmd_ready  out  1  command slot empty; transfer occurs on cmd_valid && cmd_ready
- tx_busy  in  1  UART transmitting; rises 1 cycle after an accepted tx_start
- tx_data  out  8  byte to the UART; held stable from tx_start until the byte completes
- tx_start  out  1  one-cycle start pulse
- pkt_active  out  1  high from packet launch until the last byte completes
- note_drops  out  8  saturating count of pending notes overwritten before being sent

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - tx_data=0, tx_start=0, cmd_ready=1, pkt_active=0, note_drops=0.
  - state=IDLE, last_sent=8'hFF, note_pending=0, repeat timer=0, last_grant=CMD.
- Note capture (every cycle with note_valid=1):
  - If note_code != last_sent: note_pending<=1 and pend_note<=note_code.
  - If that happens while note_pending=1 and pend_note != note_code, note_drops increments (saturates at 255).
  - If note_code == last_sent: note_pending<=0, cancelling a stale change.
- Repeat timer:
  - Counts only while last_sent != 8'hFF and no note is pending.
  - At REPEAT_CYCLES-1 it sets note_pending with pend_note=last_sent and holds at that value.
  - Clears to 0 on every note packet launch.
- Command slot: cmd_ready=0 from acceptance until that command packet launches. It reasserts the cycle after launch.
- Arbitration (IDLE only):
  - If both requesters are pending, grant the one not equal to last_grant (round-robin).
  - Otherwise grant whichever is pending.
- Launch (1 cycle, in IDLE):
  - Snapshot TYPE and PAYLOAD. Note: TYPE=8'h01, PAYLOAD=pend_note. Command: TYPE=8'h02, PAYLOAD=cmd_code.
  - CHK = TYPE ^ PAYLOAD.
  - Note launch: last_sent<=pend_note and note_pending<=0.
  - pkt_active<=1. Byte index<=0.
- Packet bytes, in order: SYNC_BYTE, TYPE, PAYLOAD, CHK.
- FSM:
  - IDLE -> LAUNCH when a request is pending.
  - LAUNCH -> SEND.
  - SEND: wait for tx_busy=0. Then drive tx_data with the current byte, pulse tx_start for 1 cycle, and go to WAIT_ACK.
  - WAIT_ACK: on tx_busy=1 go to WAIT_DONE. After ACK_TIMEOUT cycles without tx_busy, proceed as if the byte completed.
  - WAIT_DONE: on tx_busy=0, if byte index=3 go to IDLE with pkt_active<=0; else increment the index and go to SEND.
- Latency: with tx_busy idle, the first tx_start occurs 2 cycles after the request becomes pending in IDLE.
- Notes arriving mid-packet update only pend_note. The launched payload is never altered.
- tx_start never asserts while tx_busy=1, and at most once per byte.
- Reset mid-packet: return immediately to reset values. A partially sent packet is abandoned; the receiver resyncs on SYNC_BYTE.

Decomposition:
- Shared package piano_pkg holds:
  - SYNC_BYTE, TYPE_NOTE=8'h01, TYPE_CMD=8'h02, NOTE_NONE=8'hFF.
  - Enum tx_state_t {IDLE, LAUNCH, SEND, WAIT_ACK, WAIT_DONE}.
- Natural sub-module: piano_pkt_serializer (LAUNCH..WAIT_DONE sequencing plus the timeout counter). The top level keeps note dedup, the repeat timer, the command slot and arbitration.

Test Plan:
- Note 3 held on note_valid for 100 cycles, UART model busy 10 cycles per byte -> exactly one packet A5,01,03,02; then no further tx_start until REPEAT_CYCLES (bench sets 1000), then the same packet again.
- Notes 2 then 5 during an active packet, then 5 held -> next packet payload 05, CHK=04; note_drops=1.
- cmd_valid with 8'h10 while a note is pending, last_grant=CMD -> note packet first, then A5,02,10,12; cmd_ready low from acceptance until the command launches.
- UART model never raises tx_busy -> each byte advances after 16 cycles; 4 tx_start pulses, pkt_active falls after the 4th.
- Note 3 sent, then FF -> one packet A5,01,FF,FE and no repeat thereafter; note 3 then 4 then 3 before launch -> no packet.
- reset asserted during the PAYLOAD byte -> next cycle all outputs at reset values; after release, the next note is sent as a complete 4-byte packet.
